pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised program-counter unit, the next generation of the fetch-stage PC register plus incrementer. Holds the current fetch address and selects the next one from: sequential increment, absolute jump, PC-relative branch, call, or return. Adds a stall hold and an internal circular return-address stack (RAS) for call/return. Sits at the head of the fetch stage; pc_out drives instruction-memory address.

Parameters:
WIDTH, 32, address width in bits
STEP, 1, sequential increment (1 = word-addressed memory)
RESET_VECTOR, 0, pc_out value after reset
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and RAS this cycle
jump  in  1  absolute redirect to jump_target
jump_target  in  WIDTH  absolute target for jump and call
branch_taken  in  1  relative redirect
branch_offset  in  WIDTH  signed two's-complement offset added to pc_out
call  in  1  jump to jump_target and push return address
ret  in  1  pop RAS and redirect to popped address
pc_out  out  WIDTH  registered current PC
pc_seq  out  WIDTH  combinational pc_out + STEP, modulo 2^WIDTH
ras_empty  out  1  combinational, RAS count == 0
ras_full  out  1  combinational, RAS count == RAS_DEPTH
ras_overflow  out  1  registered one-cycle pulse: call while full
ras_underflow  out  1  registered one-cycle pulse: ret while empty

Behaviour:
- All state updates on rising clk; no combinational path from inputs to pc_out.
- Reset (sync, active-high, highest priority): pc_out <= RESET_VECTOR; RAS count <= 0, top pointer <= 0; ras_overflow, ras_underflow <= 0. Entry contents need not be cleared. Reset mid-call/ret discards that operation.
- Next-PC priority when not in reset, highest first:
  1. stall: pc_out, RAS and count hold; flags <= 0. Any redirect asserted with stall is dropped, not queued.
  2. ret: non-empty -> pc_out <= top entry, pop (count-1). Empty -> pc_out <= pc_seq, ras_underflow <= 1, RAS unchanged.
  3. call: pc_out <= jump_target; push pc_seq. Full -> oldest entry overwritten (circular), count stays RAS_DEPTH, ras_overflow <= 1.
  4. jump: pc_out <= jump_target.
  5. branch_taken: pc_out <= pc_out + branch_offset (base is pc_out, not pc_seq).
  6. otherwise: pc_out <= pc_seq.
- Only the highest-priority asserted request takes effect; lower ones ignored that cycle (call+ret -> ret only; call+jump -> call).
- Arithmetic: all additions WIDTH bits, wrap modulo 2^WIDTH, no carry/overflow reported.
- RAS: top pointer log2(RAS_DEPTH) bits, wraps; push writes at top+1 then advances; pop reads at top then retreats. Count saturates at 0 and RAS_DEPTH.
- Flags are one-cycle pulses, cleared in any cycle without their condition.
- Latency: redirect asserted in cycle N is visible on pc_out after edge N+1.

Test Plan:
- Reset then 3 idle cycles (WIDTH=32, STEP=1, RESET_VECTOR=0) -> pc_out 0,1,2,3; pc_seq = pc_out+1; ras_empty=1.
- pc_out=5, stall for 2 cycles with jump=1, jump_target=0x40 -> pc_out stays 5; after stall drops, idle -> 6 (jump dropped).
- pc_out=5, branch_taken, branch_offset=0xFFFFFFF8 (-8) -> pc_out 0xFFFFFFFD; then idle x3 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- pc_out=0x10 call target 0x100; at 0x100 call target 0x200; then ret, ret -> pc_out 0x100, 0x200, 0x101, 0x11; ras_empty=1 at end.
- RAS_DEPTH=4: 5 nested calls from 0x10,0x20,0x30,0x40,0x50 -> ras_overflow pulses only on 5th; 4 rets return 0x51,0x41,0x31,0x21; 5th ret -> ras_underflow pulse, pc_out = prior pc_out+1.
- call+ret same cycle with RAS top 0x21, and reset asserted during ret -> first: ret wins, no push; second: pc_out=RESET_VECTOR, ras_empty=1, no flags.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential, jump, relative branch, call and return
// with a stall hold and a circular return-address stack.
module pc_unit #(
  parameter int                 WIDTH        = 32,
  parameter int                 STEP         = 1,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  assign pc_seq        = pc_q + WIDTH'(STEP);
  assign pc_out        = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CW'(RAS_DEPTH));
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    if (stall) begin
      // redirects presented during a stall are intentionally dropped
      pc_d = pc_q;
    end else if (ret) begin
      if (ras_empty) begin
        pc_d  = pc_seq;
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (call) begin
      pc_d  = jump_target;
      push  = 1'b1;
      top_d = top_q + PW'(1);
      // when full the push lands on the oldest slot, so count stays put
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CW'(1);
    end else if (jump) begin
      pc_d = jump_target;
    end else if (branch_taken) begin
      pc_d = pc_q + branch_offset;
    end else begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) ras_q[top_d] <= pc_seq;
    end
  end

endmodule
